// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path and the baud tick generator.
// The TX side reuses the oversample constants and divider helper.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rx_state_t;

  localparam int OVS   = 16;
  localparam int MID   = 8;
  localparam int NBITS = 8;

  // Clocks per oversample tick, never below one.
  function automatic int calcDiv(input int clkHz, input int baud);
    int d;
    d = clkHz / (baud * OVS);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick at terminal count.
// restart realigns the phase so the first tick lands DIV clocks later.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rstN,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt <= '0;
    end else if (restart || cnt == TC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TC);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 16x oversampling; delivers bytes as one-cycle strobes
// and flags framing errors (stop bit low).
//
//   state | meaning
//   IDLE  | line idle, waiting for a low level on the synchronized input
//   START | counting to mid start bit to reject glitches
//   DATA  | sampling 8 data bits, LSB first, every 16th tick
//   STOP  | waiting for mid stop bit; emit byte or framing error
//   BRK   | line stuck low after framing error, wait for it to go high
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       iCLK_50,
  input  logic       iRST_N,
  input  logic       iUART_RXD,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oFERR,
  output logic       oBUSY
);

  localparam int DIV = calcDiv(CLK_HZ, BAUD);
  localparam logic [3:0] SAMPLE_MID  = 4'(MID - 1);
  localparam logic [3:0] SAMPLE_LAST = 4'(OVS - 1);
  localparam logic [2:0] BIT_LAST    = 3'(NBITS - 1);

  logic rxdMeta, rxdS;
  logic restart, tick;

  rx_state_t        state, stateNext;
  logic [3:0]       sampleCnt, sampleCntNext;
  logic [2:0]       bitCnt, bitCntNext;
  logic [NBITS-1:0] shiftReg, shiftNext;
  logic [7:0]       dataQ, dataNext;
  logic             validQ, validNext;
  logic             ferrQ, ferrNext;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      rxdMeta <= 1'b1;
      rxdS    <= 1'b1;
    end else begin
      rxdMeta <= iUART_RXD;
      rxdS    <= rxdMeta;
    end
  end

  assign restart = (state == IDLE) && !rxdS;

  uart_baud_tick #(.DIV(DIV)) uBaudTick (
    .clk    (iCLK_50),
    .rstN   (iRST_N),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      sampleCnt <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      dataQ     <= '0;
      validQ    <= 1'b0;
      ferrQ     <= 1'b0;
    end else begin
      state     <= stateNext;
      sampleCnt <= sampleCntNext;
      bitCnt    <= bitCntNext;
      shiftReg  <= shiftNext;
      dataQ     <= dataNext;
      validQ    <= validNext;
      ferrQ     <= ferrNext;
    end
  end

  always_comb begin
    stateNext     = state;
    sampleCntNext = sampleCnt;
    bitCntNext    = bitCnt;
    shiftNext     = shiftReg;
    dataNext      = dataQ;
    validNext     = 1'b0;
    ferrNext      = 1'b0;
    case (state)
      IDLE: begin
        if (!rxdS) begin
          stateNext     = START;
          sampleCntNext = '0;
          bitCntNext    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (sampleCnt == SAMPLE_MID) begin
            sampleCntNext = '0;
            stateNext     = rxdS ? IDLE : DATA;
          end else begin
            sampleCntNext = sampleCnt + 4'd1;
          end
        end
      end
      DATA: begin
        // Sample counter wraps at 16, so each bit is sampled one bit time later.
        if (tick) begin
          sampleCntNext = sampleCnt + 4'd1;
          if (sampleCnt == SAMPLE_LAST) begin
            shiftNext = {rxdS, shiftReg[NBITS-1:1]};
            if (bitCnt == BIT_LAST) begin
              stateNext = STOP;
            end else begin
              bitCntNext = bitCnt + 3'd1;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          sampleCntNext = sampleCnt + 4'd1;
          if (sampleCnt == SAMPLE_LAST) begin
            if (rxdS) begin
              dataNext  = shiftReg;
              validNext = 1'b1;
              stateNext = IDLE;
            end else begin
              ferrNext  = 1'b1;
              stateNext = BRK;
            end
          end
        end
      end
      BRK: begin
        if (rxdS) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign oDATA  = dataQ;
  assign oVALID = validQ;
  assign oFERR  = ferrQ;
  assign oBUSY  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at DIV=1 (one bit = 16 clocks).
// A negedge monitor tallies output pulses; the initial block checks the tallies.
module tb_uart_rx_byte;

  logic       clk  = 1'b0;
  logic       rstN = 1'b0;
  logic       rxd  = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, busy;

  uart_rx_byte #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
    .iCLK_50  (clk),
    .iRST_N   (rstN),
    .iUART_RXD(rxd),
    .oDATA    (data),
    .oVALID   (valid),
    .oFERR    (ferr),
    .oBUSY    (busy)
  );

  always #5 clk = ~clk;

  int testCnt = 0;
  int failCnt = 0;

  int cyc = 0;
  int validCnt = 0, ferrCnt = 0, busyCnt = 0, bothCnt = 0;
  int lastValidCyc = 0, prevValidCyc = 0;
  logic [7:0] dataLog [0:15];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      dataLog[validCnt % 16] = data;
      prevValidCyc = lastValidCyc;
      lastValidCyc = cyc;
      validCnt++;
    end
    if (ferr) ferrCnt++;
    if (busy) busyCnt++;
    if (valid && ferr) bothCnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    assert (obs === exp)
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int startCyc = 0;
  int busyRise = 0;

  task automatic driveBits(input logic b, input int n);
    rxd = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    startCyc = cyc;
    busyRise = 0;
    rxd = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (busy && busyRise == 0) busyRise = i;
    end
    for (int i = 0; i < 8; i++) driveBits(b[i], 16);
    driveBits(stopBit, 16);
  endtask

  int v0, f0, b0, n;
  logic seenBusy;

  initial begin
    // Reset and idle
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rstN = 1'b1;
    v0 = validCnt; f0 = ferrCnt; b0 = busyCnt;
    repeat (200) @(negedge clk);
    #1;
    chk("idle_data", data, 8'h00);
    chk("idle_valid_cnt", validCnt - v0, 0);
    chk("idle_ferr_cnt", ferrCnt - f0, 0);
    chk("idle_busy_cnt", busyCnt - b0, 0);

    // Single frame 0x55
    v0 = validCnt; f0 = ferrCnt;
    sendFrame(8'h55, 1'b1);
    driveBits(1'b1, 20);
    #1;
    chk("f55_busy_rise", busyRise, 3);
    chk("f55_valid_cnt", validCnt - v0, 1);
    chk("f55_log", dataLog[v0 % 16], 8'h55);
    chk("f55_data", data, 8'h55);
    chk("f55_latency", lastValidCyc - startCyc, 155);
    chk("f55_ferr_cnt", ferrCnt - f0, 0);
    chk("f55_busy_after", busy, 1'b0);

    // Back-to-back 0xA5, 0x3C
    v0 = validCnt; f0 = ferrCnt;
    sendFrame(8'hA5, 1'b1);
    sendFrame(8'h3C, 1'b1);
    driveBits(1'b1, 20);
    #1;
    chk("b2b_valid_cnt", validCnt - v0, 2);
    chk("b2b_first", dataLog[v0 % 16], 8'hA5);
    chk("b2b_second", dataLog[(v0 + 1) % 16], 8'h3C);
    chk("b2b_spacing", lastValidCyc - prevValidCyc, 160);
    chk("b2b_ferr_cnt", ferrCnt - f0, 0);
    chk("b2b_data", data, 8'h3C);

    // Glitch rejection
    v0 = validCnt; f0 = ferrCnt;
    seenBusy = 1'b0;
    rxd = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy) seenBusy = 1'b1;
    end
    rxd = 1'b1;
    n = 0;
    while ((busy || !seenBusy) && n < 10) begin
      @(negedge clk);
      if (busy) seenBusy = 1'b1;
      n++;
    end
    chk("glitch_busy_seen", seenBusy, 1'b1);
    chk("glitch_busy_low", busy, 1'b0);
    driveBits(1'b1, 30);
    #1;
    chk("glitch_valid_cnt", validCnt - v0, 0);
    chk("glitch_ferr_cnt", ferrCnt - f0, 0);
    sendFrame(8'h0F, 1'b1);
    driveBits(1'b1, 20);
    #1;
    chk("f0f_valid_cnt", validCnt - v0, 1);
    chk("f0f_data", data, 8'h0F);

    // Framing error then break
    v0 = validCnt; f0 = ferrCnt;
    sendFrame(8'hFF, 1'b0);
    driveBits(1'b0, 100);
    #1;
    chk("ferr_cnt", ferrCnt - f0, 1);
    chk("ferr_valid_cnt", validCnt - v0, 0);
    chk("ferr_data_held", data, 8'h0F);
    chk("ferr_busy_brk", busy, 1'b1);
    chk("ferr_no_overlap", bothCnt, 0);
    driveBits(1'b1, 20);
    #1;
    chk("brk_exit_busy", busy, 1'b0);
    chk("brk_ferr_cnt", ferrCnt - f0, 1);
    sendFrame(8'h12, 1'b1);
    driveBits(1'b1, 20);
    #1;
    chk("f12_valid_cnt", validCnt - v0, 1);
    chk("f12_data", data, 8'h12);

    // Reset mid-frame of 0x80 (during bit 4)
    v0 = validCnt; f0 = ferrCnt;
    driveBits(1'b0, 16);
    for (int i = 0; i < 4; i++) driveBits(1'b0, 16);
    driveBits(1'b0, 5);
    #1;
    rstN = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_valid", valid, 1'b0);
    @(negedge clk);
    driveBits(1'b0, 10);
    driveBits(1'b0, 32);
    driveBits(1'b1, 16);
    driveBits(1'b1, 16);
    driveBits(1'b1, 5);
    rstN = 1'b1;
    driveBits(1'b1, 30);
    #1;
    chk("mid_rst_valid_cnt", validCnt - v0, 0);
    chk("mid_rst_ferr_cnt", ferrCnt - f0, 0);
    chk("mid_rst_data_after", data, 8'h00);
    sendFrame(8'h31, 1'b1);
    driveBits(1'b1, 20);
    #1;
    chk("f31_valid_cnt", validCnt - v0, 1);
    chk("f31_data", data, 8'h31);
    chk("final_no_overlap", bothCnt, 0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
